// File: rtl/jk_bank_sequencer.sv
// Command sequencer for a bank of JK flops: accepts one command per handshake and
// drives registered j/k for the programmed cycle count. Optional feature: JKSEQ_VERIFY_EN.
module jk_bank_sequencer #(
  parameter int N_FF  = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [N_FF-1:0]  cmd_mask,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic [N_FF-1:0]  j,
  output logic [N_FF-1:0]  k,
  input  logic [N_FF-1:0]  q_in,
  output logic             busy,
  output logic             done,
`ifdef JKSEQ_VERIFY_EN
  output logic             err,
  output logic [N_FF-1:0]  mismatch,
`endif
  output logic [1:0]       state_dbg
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // the source holds cmd_valid and the bus stable until then, and the bus is
  // looked at only on that edge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [N_FF-1:0]  j_q, j_d;
  logic [N_FF-1:0]  k_q, k_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_valid) state_d = RUN;
      RUN:  if (remaining_q == CNT_W'(1) || abort) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q == RUN) || (state_q == DONE);
    done      = (state_q == DONE);
    state_dbg = state_q;
    j         = j_q;
    k         = k_q;
  end

  // op bit 1 drives J and op bit 0 drives K, which yields hold/clear/set/toggle.
  always_comb begin
    remaining_d = remaining_q;
    j_d         = j_q;
    k_d         = k_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          remaining_d = (cmd_count == '0) ? CNT_W'(1) : cmd_count;
          j_d         = cmd_op[1] ? cmd_mask : '0;
          k_d         = cmd_op[0] ? cmd_mask : '0;
        end
      end
      RUN: begin
        remaining_d = remaining_q - CNT_W'(1);
        if (state_d == DONE) begin
          j_d = '0;
          k_d = '0;
        end
      end
      default: begin
        j_d = '0;
        k_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= '0;
      j_q         <= '0;
      k_q         <= '0;
    end else begin
      remaining_q <= remaining_d;
      j_q         <= j_d;
      k_q         <= k_d;
    end
  end

`ifdef JKSEQ_VERIFY_EN
  logic [N_FF-1:0] shadow_q, shadow_d;
  logic [N_FF-1:0] mismatch_q, mismatch_d;
  logic            err_q, err_d;

  // The shadow follows the bank only on RUN edges, the only edges that apply j/k.
  always_comb begin
    shadow_d   = shadow_q;
    mismatch_d = mismatch_q;
    err_d      = err_q;
    if (state_q == RUN) begin
      shadow_d = (j_q & ~shadow_q) | (~k_q & shadow_q);
    end
    if (state_q == DONE) begin
      mismatch_d = shadow_q ^ q_in;
      err_d      = err_q | (|(shadow_q ^ q_in));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q   <= '0;
      mismatch_q <= '0;
      err_q      <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

  assign err      = err_q;
  assign mismatch = mismatch_q;
`else
  logic unused_q_in;
  assign unused_q_in = ^q_in;
`endif

endmodule
